// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: one-hot row drive, press/release debounce, and a
// first-word-fall-through keycode queue with a valid/ready consumer handshake.
module keypad_scan_ctrl #(
    parameter int DIV_W      = 16,
    parameter int DEB_CNT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          fin,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [2:0]                    colum,
    output logic [3:0]                    scan,
    output logic [3:0]                    keycode,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic                          key_held,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic [1:0] col_index(input logic [2:0] c);
        case (c)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [DW-1:0]    deb_q, deb_d, deb_inc_s;
    logic [2:0]       pat_q, pat_d;
    logic [3:0]       code_q, code_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [3:0]       mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       scan_q, scan_d;
    logic [3:0]       keycode_q, keycode_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             tick_s, push_s, pop_s, full_s, wr_en_s;
    logic [3:0]       push_code_s;

    assign tick_s    = enable && (div_q == {DIV_W{1'b1}});
    assign deb_inc_s = deb_q + DW'(1);

    // Scan divider and keypad state machine next-state
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        deb_d       = deb_q;
        pat_d       = pat_q;
        code_d      = code_q;
        push_s      = 1'b0;
        push_code_s = code_q;
        if (enable) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = div_q;
        end
        if (!enable) begin
            state_d = SCAN;
            deb_d   = {DW{1'b0}};
        end else if (tick_s) begin
            case (state_q)
                SCAN: begin
                    if (colum == 3'b000) begin
                        row_d = row_q + 2'd1;
                    end else if (is_onehot(colum)) begin
                        code_d = {col_index(colum), row_q};
                        pat_d  = colum;
                        deb_d  = DW'(1);
                        if (DEB_CNT == 1) begin
                            push_s      = 1'b1;
                            push_code_s = {col_index(colum), row_q};
                            state_d     = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        // ghosting: hold the row until the pattern clears
                        state_d = SCAN;
                    end
                end
                DEBOUNCE: begin
                    if (colum == pat_q) begin
                        deb_d = deb_inc_s;
                        if (deb_inc_s == DEB_MAX) begin
                            push_s  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (colum == 3'b000) begin
                        deb_d = DW'(1);
                        if (DEB_CNT == 1) begin
                            state_d = SCAN;
                            row_d   = row_q + 2'd1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                RELEASE: begin
                    if (colum == 3'b000) begin
                        deb_d = deb_inc_s;
                        if (deb_inc_s == DEB_MAX) begin
                            state_d = SCAN;
                            row_d   = row_q + 2'd1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Keycode queue next-state; outputs are precomputed from the next state
    always_comb begin
        mem_d   = mem_q;
        pop_s   = valid_q && key_ready;
        full_s  = (cnt_q == FULL_CNT);
        wr_en_s = push_s && (!full_s || pop_s);
        if (wr_en_s) begin
            mem_d[wr_q] = push_code_s;
            wr_d        = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q | (push_s && full_s && !pop_s);
        if (cnt_d != {CW{1'b0}}) begin
            keycode_d = mem_d[rd_d];
            valid_d   = 1'b1;
        end else begin
            keycode_d = 4'b0000;
            valid_d   = 1'b0;
        end
        scan_d = 4'b0001 << row_d;
        held_d = (state_d == HELD) || (state_d == RELEASE);
    end

    // All state registers
    always_ff @(posedge fin or posedge rst) begin
        if (rst) begin
            div_q     <= {DIV_W{1'b0}};
            state_q   <= SCAN;
            row_q     <= 2'd0;
            deb_q     <= {DW{1'b0}};
            pat_q     <= 3'b000;
            code_q    <= 4'b0000;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'b0000;
            end
            wr_q      <= {AW{1'b0}};
            rd_q      <= {AW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            ovf_q     <= 1'b0;
            scan_q    <= 4'b0001;
            keycode_q <= 4'b0000;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            row_q     <= row_d;
            deb_q     <= deb_d;
            pat_q     <= pat_d;
            code_q    <= code_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            scan_q    <= scan_d;
            keycode_q <= keycode_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    assign scan       = scan_q;
    assign keycode    = keycode_q;
    assign key_valid  = valid_q;
    assign key_held   = held_q;
    assign overflow   = ovf_q;
    assign fifo_count = cnt_q;

endmodule
